// File: rtl/idft_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the IDFT core slave port.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   mN_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i   master N request (N = 0, 1)
//   mN_dat_o/ack_o/err_o     response to master N (zero unless granted)
//   s_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o    request to the IDFT core
//   s_dat_i, s_ack_i         IDFT core response
//   timeout_o                one-cycle pulse when a stalled access is aborted
//
// A master that wins the grant keeps the bus for as long as it holds cyc.
// Ties from the idle state go to the master that was not served last.
// A strobe stalled for TIMEOUT cycles is answered with err instead of ack.
module idft_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,

  output logic          timeout_o
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_t;

  gnt_t        gnt;
  logic        last;   // 0: M0 served last, 1: M1 served last
  logic [15:0] cnt;    // consecutive stalled strobe cycles

  logic sel0;
  logic sel1;
  logic g_cyc;
  logic g_stb;
  logic tmo;

  // Grant selects are qualified with reset so nothing leaks out while
  // reset is held, even before the first reset edge clears the state.
  always_comb begin
    sel0  = rst_ni && (gnt == GNT_M0);
    sel1  = rst_ni && (gnt == GNT_M1);
    g_cyc = (sel0 && m0_cyc_i) || (sel1 && m1_cyc_i);
    g_stb = (sel0 && m0_stb_i) || (sel1 && m1_stb_i);
    // An ack in the same cycle as the limit always wins over the timeout.
    tmo   = g_cyc && g_stb && !s_ack_i && (cnt == 16'(TIMEOUT));
  end

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    if (sel0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
    end else if (sel1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
    end
    // The aborted strobe is withdrawn from the core in the timeout cycle.
    s_cyc_o   = g_cyc && !tmo;
    s_stb_o   = g_stb && !tmo;
    m0_ack_o  = sel0 && s_ack_i;
    m1_ack_o  = sel1 && s_ack_i;
    m0_dat_o  = sel0 ? s_dat_i : '0;
    m1_dat_o  = sel1 ? s_dat_i : '0;
    m0_err_o  = sel0 && tmo;
    m1_err_o  = sel1 && tmo;
    timeout_o = tmo;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gnt  <= GNT_NONE;
      last <= 1'b1;
      cnt  <= '0;
    end else begin
      case (gnt)
        GNT_NONE: begin
          cnt <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            gnt  <= GNT_M0;
            last <= 1'b0;
          end else if (m1_cyc_i) begin
            gnt  <= GNT_M1;
            last <= 1'b1;
          end
        end
        GNT_M0, GNT_M1: begin
          // Release always passes through GNT_NONE; no direct handover.
          if (!g_cyc) begin
            gnt <= GNT_NONE;
            cnt <= '0;
          end else if (tmo || s_ack_i || !g_stb) begin
            cnt <= '0;
          end else if (s_cyc_o && s_stb_o) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          gnt <= GNT_NONE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idft_wb_arbiter.sv
module tb_idft_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [AW-1:0] A0 = 32'h1000_0040;
  localparam logic [AW-1:0] A1 = 32'h2000_0080;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, timeout_o;

  always #5 clk_i = ~clk_i;

  idft_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .timeout_o(timeout_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which master owns the bus (-1 = nobody), who was
  // served last, and how many stalled strobe cycles have elapsed.
  int owner = -1;
  int last  = 1;
  int stall = 0;

  // Observations accumulated from the DUT outputs.
  int ack0_cnt, ack1_cnt, err0_cnt, err1_cnt, tmo_cnt;
  bit obs_ack0, obs_ack1, prev_scyc;
  int glog[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    ack0_cnt = 0; ack1_cnt = 0; err0_cnt = 0; err1_cnt = 0; tmo_cnt = 0;
  endtask

  // One clock: compare outputs against the model for the current inputs,
  // then advance the model across the rising edge. Entered and left at negedge.
  task automatic cycle();
    logic [70:0] e_s;
    logic [33:0] e_m0, e_m1;
    logic        e_to;
    bit          tmo, ccyc, cstb;
    #1;
    e_s = '0; e_m0 = '0; e_m1 = '0; e_to = 1'b0; tmo = 0;
    if (rst_ni && owner == 0) begin
      tmo  = m0_cyc_i && m0_stb_i && stall == TO && !s_ack_i;
      e_s  = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i && !tmo, m0_stb_i && !tmo};
      e_m0 = {s_dat_i, s_ack_i, tmo};
    end else if (rst_ni && owner == 1) begin
      tmo  = m1_cyc_i && m1_stb_i && stall == TO && !s_ack_i;
      e_s  = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i && !tmo, m1_stb_i && !tmo};
      e_m1 = {s_dat_i, s_ack_i, tmo};
    end
    e_to = tmo;
    chk("slave_bus", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o}, e_s);
    chk("m0_resp", {m0_dat_o, m0_ack_o, m0_err_o}, e_m0);
    chk("m1_resp", {m1_dat_o, m1_ack_o, m1_err_o}, e_m1);
    chk("timeout", timeout_o, e_to);

    obs_ack0 = (m0_ack_o === 1'b1);
    obs_ack1 = (m1_ack_o === 1'b1);
    if (obs_ack0) ack0_cnt++;
    if (obs_ack1) ack1_cnt++;
    if (m0_err_o === 1'b1) err0_cnt++;
    if (m1_err_o === 1'b1) err1_cnt++;
    if (timeout_o === 1'b1) tmo_cnt++;
    if (s_cyc_o === 1'b1 && !prev_scyc) glog.push_back((s_adr_o === A0) ? 0 : 1);
    prev_scyc = (s_cyc_o === 1'b1);

    @(posedge clk_i);
    if (!rst_ni) begin
      owner = -1; last = 1; stall = 0;
    end else if (owner < 0) begin
      stall = 0;
      if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
      else if (m0_cyc_i)        owner = 0;
      else if (m1_cyc_i)        owner = 1;
      if (owner >= 0) last = owner;
    end else begin
      ccyc = (owner == 0) ? m0_cyc_i : m1_cyc_i;
      cstb = (owner == 0) ? m0_stb_i : m1_stb_i;
      if (!ccyc) begin
        owner = -1; stall = 0;
      end else if (tmo || s_ack_i || !cstb) begin
        stall = 0;
      end else begin
        stall++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
  endtask

  initial begin
    bit rest0, rest1;
    rst_ni = 0;
    m0_adr_i = A0; m0_dat_i = 32'h0000_00a5; m0_sel_i = 4'hf; m0_we_i = 1;
    m1_adr_i = A1; m1_dat_i = 32'h0000_005a; m1_sel_i = 4'h3; m1_we_i = 0;
    s_dat_i = 32'hdead_beef;
    idle();
    @(negedge clk_i);

    // Reset, then simultaneous requests: M0 wins the first tie.
    repeat (2) cycle();
    chk("reset_outputs", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, timeout_o, s_adr_o}, '0);
    rst_ni = 1;
    clr_obs();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    cycle();
    chk("tie_grant_m0", {s_cyc_o, s_adr_o}, {1'b1, A0});

    // M0 locks the bus for three strobes, each acked on its third cycle.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        s_ack_i = (j == 2);
        s_dat_i = $urandom;
        cycle();
      end
    end
    s_ack_i = 0;
    chk("m0_three_acks", ack0_cnt, 3);
    chk("m1_no_ack_while_m0", ack1_cnt, 0);
    m0_cyc_i = 0; m0_stb_i = 0;
    cycle();
    chk("release_to_none", {s_cyc_o, s_adr_o}, '0);
    cycle();
    chk("m1_granted_after_drop", {s_cyc_o, s_adr_o}, {1'b1, A1});
    s_ack_i = 1; cycle();
    idle(); repeat (2) cycle();

    // Both masters request continuously; grants must alternate.
    rest0 = 0; rest1 = 0;
    glog.delete();
    for (int n = 0; n < 200 && glog.size() < 8; n++) begin
      m0_cyc_i = !rest0; m0_stb_i = !rest0;
      m1_cyc_i = !rest1; m1_stb_i = !rest1;
      s_ack_i = 0;
      #1;
      s_ack_i = s_stb_o;
      s_dat_i = $urandom;
      cycle();
      rest0 = obs_ack0;
      rest1 = obs_ack1;
    end
    chk("alt_grant_count", glog.size(), 8);
    for (int k = 0; k < glog.size(); k++) chk($sformatf("alt_grant_%0d", k), glog[k], k % 2);
    idle(); repeat (3) cycle();

    // Core never acks: err/timeout for exactly one cycle, grant retained.
    clr_obs();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
    cycle();
    chk("stall_start", {s_cyc_o, s_stb_o, timeout_o}, 3'b110);
    repeat (TO) cycle();
    chk("timeout_pulse", {m0_err_o, timeout_o, s_stb_o, s_cyc_o, m1_err_o}, 5'b11000);
    cycle();
    chk("after_timeout", {m0_err_o, timeout_o, s_stb_o, s_cyc_o, s_adr_o}, {4'b0011, A0});
    chk("one_timeout", tmo_cnt, 1);
    chk("one_err_m0", err0_cnt, 1);
    idle(); repeat (2) cycle();

    // Ack on the cycle the stall limit is reached: ack wins.
    clr_obs();
    m1_cyc_i = 1; m1_stb_i = 1;
    cycle();
    repeat (TO) cycle();
    s_ack_i = 1; s_dat_i = $urandom;
    #1;
    chk("ack_wins", {m1_ack_o, m1_err_o, timeout_o, s_stb_o}, 4'b1001);
    cycle();
    idle(); repeat (2) cycle();
    chk("ack_wins_no_timeout", {tmo_cnt[7:0], err1_cnt[7:0]}, '0);

    // Reset pulse in the middle of an M1 read aborts it silently.
    clr_obs();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
    cycle(); cycle();
    rst_ni = 0; s_ack_i = 1;
    cycle();
    rst_ni = 1; s_ack_i = 0;
    chk("reset_abort_outputs",
        {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, m0_dat_o, m0_ack_o, m0_err_o,
         m1_dat_o[15:0], m1_ack_o, m1_err_o, timeout_o}, '0);
    chk("reset_abort_m1_dat", m1_dat_o, '0);
    cycle();
    chk("reset_no_resp", {ack1_cnt[7:0], err1_cnt[7:0], ack0_cnt[7:0]}, '0);
    chk("regrant_after_reset", {s_cyc_o, s_adr_o}, {1'b1, A1});
    idle(); repeat (2) cycle();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst_ni = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      s_ack_i = ($urandom_range(0, 2) == 0);
      s_dat_i = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
